// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter, MSB first, with a fixed idle gap after each word.
// Ports: clk (rising edge), rst (async active-low), load_valid/load_data/load_ready (word handshake),
//        ser_out/ser_valid (serial bit stream), done (pulse on the final bit of a word).
// Optional: define SER_PARITY_EN to append an even-parity bit after the data bits.
module serial_word_tx #(
    parameter int WIDTH = 3,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);
    localparam int MAXC = (WIDTH - 1 > GAP) ? WIDTH - 1 : GAP;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] W_LOAD   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef SER_PARITY_EN
        GAP_WAIT,
        PARITY
`else
        GAP_WAIT
`endif
    } state_t;
    localparam state_t AFTER_WORD = (GAP > 0) ? GAP_WAIT : IDLE;
    state_t          state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]   cnt;
`ifdef SER_PARITY_EN
    logic            par;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (load_valid) begin
                    sr    <= load_data;
                    cnt   <= W_LOAD;
                    state <= SHIFT;
`ifdef SER_PARITY_EN
                    par   <= ^load_data;
`endif
                end
                SHIFT: if (cnt == '0) begin
`ifdef SER_PARITY_EN
                    state <= PARITY;
`else
                    state <= AFTER_WORD;
`endif
                    cnt   <= GAP_LOAD;
                end else begin
                    sr  <= sr << 1;
                    cnt <= cnt - 1'b1;
                end
                GAP_WAIT: if (cnt == '0) state <= IDLE; else cnt <= cnt - 1'b1;
`ifdef SER_PARITY_EN
                PARITY: state <= AFTER_WORD;
`endif
                default: state <= IDLE;
            endcase
        end
    end
    // Outputs decode only from flops, so reset clears them immediately.
    always_comb begin
        load_ready = rst && state == IDLE;
`ifdef SER_PARITY_EN
        ser_valid  = state == SHIFT || state == PARITY;
        ser_out    = (state == SHIFT && sr[WIDTH-1]) || (state == PARITY && par);
        done       = state == PARITY;
`else
        ser_valid  = state == SHIFT;
        ser_out    = state == SHIFT && sr[WIDTH-1];
        done       = state == SHIFT && cnt == '0;
`endif
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed self-checking bench for serial_word_tx (WIDTH=3/GAP=1 and WIDTH=4/GAP=0).
module tb_serial_word_tx;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB  = 3 + PB;
    localparam int NB1 = 4 + PB;
    localparam int GP  = 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lv = 1'b0;
    logic [2:0] ld = '0;
    logic rdy, so, sv, dn;
    logic lv1 = 1'b0;
    logic [3:0] ld1 = '0;
    logic rdy1, so1, sv1, dn1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_cyc = 0;
    int prev_cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    serial_word_tx u0 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
        .load_ready(rdy), .ser_out(so), .ser_valid(sv), .done(dn)
    );
    serial_word_tx #(.WIDTH(4), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1),
        .load_ready(rdy1), .ser_out(so1), .ser_valid(sv1), .done(dn1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    // Call so that the next negedge falls in an IDLE cycle of u0.
    task automatic tx_word(input logic [2:0] w, input logic hold, input logic [2:0] nxt);
        logic [3:0] bits;
        bits = {w, ^w};
        ld = w;
        lv = 1'b1;
        @(negedge clk);
        chk("idle_rdy", rdy, 1);
        chk("idle_sv", sv, 0);
        @(posedge clk);
        #1;
        lv = hold;
        ld = nxt;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0) first_cyc = cyc;
            chk("bit", so, bits[3-k]);
            chk("bit_sv", sv, 1);
            chk("bit_done", dn, k == NB - 1);
            chk("busy_rdy", rdy, 0);
        end
        for (int g = 0; g < GP; g++) begin
            @(negedge clk);
            chk("gap_sv", sv, 0);
            chk("gap_so", so, 0);
            chk("gap_done", dn, 0);
            chk("gap_rdy", rdy, 0);
        end
    endtask
    initial begin
        logic [3:0] w1;
        logic [4:0] bits1;
        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_sv", sv, 0);
        chk("rst_so", so, 0);
        chk("rst_done", dn, 0);
        chk("rst_rdy1", rdy1, 0);
        #1 rst = 1'b1;
        #1 chk("rel_rdy", rdy, 1);
        @(posedge clk);
        #1;
        tx_word(3'b101, 1'b0, 3'b101);
        tx_word(3'b110, 1'b1, 3'b110);
        prev_cyc = first_cyc;
        tx_word(3'b011, 1'b0, 3'b011);
        chk("period", first_cyc - prev_cyc, NB + GP + 1);
        tx_word(3'b000, 1'b1, 3'b111);
        tx_word(3'b111, 1'b0, 3'b111);
        ld = 3'b111;
        lv = 1'b1;
        @(negedge clk);
        chk("ar_rdy", rdy, 1);
        @(posedge clk);
        #1 lv = 1'b0;
        @(negedge clk);
        chk("ar_b0", so, 1);
        @(negedge clk);
        chk("ar_b1", so, 1);
        #1 rst = 1'b0;
        #1;
        chk("ar_so", so, 0);
        chk("ar_sv", sv, 0);
        chk("ar_done", dn, 0);
        chk("ar_rdy_low", rdy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("ar_hold_sv", sv, 0);
            chk("ar_hold_done", dn, 0);
        end
        #1 rst = 1'b1;
        #1 chk("ar_rel_rdy", rdy, 1);
        @(posedge clk);
        #1;
        tx_word(3'b010, 1'b0, 3'b010);
        w1 = 4'b1001;
        bits1 = {w1, ^w1};
        @(posedge clk);
        #1;
        lv1 = 1'b1;
        ld1 = w1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("g0_idle_rdy", rdy1, 1);
            chk("g0_idle_sv", sv1, 0);
            for (int k = 0; k < NB1; k++) begin
                @(negedge clk);
                chk("g0_bit", so1, bits1[4-k]);
                chk("g0_sv", sv1, 1);
                chk("g0_done", dn1, k == NB1 - 1);
                chk("g0_rdy", rdy1, 0);
            end
        end
        @(negedge clk);
        chk("g0_idle_end", sv1, 0);
        lv1 = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 3, number of data bits per word (legal range 1..32).
REQ-002 Parameter GAP SHALL be: GAP, default 1, number of idle cycles inserted after each word (legal range 0..15).
REQ-003 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be: rst  input  1  asynchronous, active-low reset.
REQ-005 Port load_valid SHALL be: load_valid  input  1  a parallel word is offered.
REQ-006 Port load_data SHALL be: load_data  input  WIDTH  word to serialise, MSB sent first.
REQ-007 Port load_ready SHALL be: load_ready  output  1  block can accept a word this cycle.
REQ-008 Port ser_out SHALL be: ser_out  output  1  serial bit stream toward the downstream sequence FSM input.
REQ-009 Port ser_valid SHALL be: ser_valid  output  1  ser_out carries a word bit this cycle.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse on the final bit of a word.

Function
REQ-011 The state machine SHALL have states IDLE, SHIFT and GAP_WAIT, plus PARITY when SER_PARITY_EN is defined.
REQ-012 load_ready SHALL equal (state==IDLE) AND rst; it is 0 in every other state and while rst is low.
REQ-013 A handshake SHALL occur on a rising edge where load_valid and load_ready are both 1; load_data is captured into a WIDTH-bit shift register, bit counter set to WIDTH-1, state -> SHIFT.
REQ-014 In SHIFT, ser_out SHALL be the shift-register MSB, ser_valid 1; each edge shifts left by one (LSB fill 0) and decrements the counter.
REQ-015 Latency: first bit SHALL appear in the cycle immediately following the accepting edge; bit k (0 = MSB) SHALL appear k+1 cycles after accept.
REQ-016 When the counter reaches 0 in SHIFT, done SHALL be 1 for that cycle; next state -> PARITY if enabled, else GAP_WAIT if GAP>0, else IDLE.
REQ-017 GAP_WAIT SHALL last exactly GAP cycles with ser_out=0, ser_valid=0, then -> IDLE.
REQ-018 In IDLE and GAP_WAIT, ser_out, ser_valid and done SHALL be 0.
REQ-019 load_valid and load_data changes outside IDLE SHALL be ignored; the word in flight is never altered.
REQ-020 Word period with load_valid held high SHALL be WIDTH + GAP + 1 cycles (+1 with parity); the IDLE cycle is never skipped.
REQ-021 Counters SHALL be sized to hold max(WIDTH-1, GAP) with no wrap-around; GAP=0 transitions SHIFT -> IDLE directly.

Reset
REQ-022 rst low SHALL asynchronously force state=IDLE, shift register=0, counter=0, ser_out=0, ser_valid=0, done=0, load_ready=0.
REQ-023 Reset asserted mid-word SHALL abandon the word with no further bits or done pulse; the first edge after rst goes high sees load_ready=1.

Configuration
REQ-024 Macro SER_PARITY_EN SHALL, when defined, add state PARITY: one cycle after the last data bit, ser_out = XOR of the captured word (even parity), ser_valid=1, done=1 moved from the last data bit to this cycle.
REQ-025 Without SER_PARITY_EN, no PARITY state or parity logic SHALL exist and done falls on the last data bit.

Verification
REQ-026 WIDTH=3, GAP=1: reset, release, load 3'b101 -> ser_out 1,0,1 over cycles 1-3, ser_valid high 3 cycles, done in cycle 3, gap in cycle 4, load_ready=1 in cycle 5.
REQ-027 load_valid held high with 3'b110 then 3'b011 -> streams 1,1,0 then 0,1,1; second word's first bit 5 cycles after the first's.
REQ-028 Shift 3'b000 while load_data=3'b111 and load_valid=1 during SHIFT -> output 0,0,0; 3'b111 accepted only at the next IDLE.
REQ-029 rst low after the 2nd bit of 3'b111 -> ser_out, ser_valid, done drop to 0 without waiting for a clock edge; after release load 3'b010 -> clean 0,1,0 with one done.
REQ-030 SER_PARITY_EN defined: 3'b101 -> 1,0,1,0 and 3'b100 -> 1,0,0,1, done on the 4th bit, period 6 cycles.
REQ-031 GAP=0, WIDTH=4, load_valid held with 4'b1001 -> 1,0,0,1 repeated every 5 cycles, ser_valid low exactly in the IDLE cycle.
